// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder.
//   - SPI opcodes understood by the responder
//   - address-advance modes held in status[7:6]
//   - protocol FSM state type
package spi_sram_pkg;

  localparam logic [7:0] CMD_WRSR  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WRSR,
    ST_RDSR,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_sram_responder_if.sv
// SPI link bundle between an SRAM controller (master) and the responder.
//   clk   : system clock the link is observed in
//   sck   : serial clock, idle low
//   cs    : chip select, active low
//   si    : serial data towards the responder
//   so    : serial data from the responder
//   so_oe : so carries valid read/status data
interface spi_sram_responder_if (
  input logic clk
);
  logic sck;
  logic cs;
  logic si;
  logic so;
  logic so_oe;

  modport master (input clk, output sck, output cs, output si, input so, input so_oe);
  modport slave  (input clk, input sck, input cs, input si, output so, output so_oe);
endinterface

// File: rtl/spi_sram_array.sv
// Byte array behind the SPI SRAM responder.
//   i_clk/i_rst  : clock, synchronous active-high reset (backdoor register only)
//   i_we/i_re    : functional port write / read enable
//   i_addr       : functional port address
//   i_wdata      : functional port write data
//   o_rdata      : functional port read data, registered, held between reads
//   i_bd_addr    : backdoor read address
//   o_bd_rdata   : backdoor read data, registered; returns old data on a
//                  same-cycle write
module spi_sram_array #(
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata,
  input  logic [ADDR_W-1:0] i_bd_addr,
  output logic [7:0]        o_bd_rdata
);

  logic [7:0] mem_q [0:(1<<ADDR_W)-1];
  logic [7:0] rdata_q;
  logic [7:0] bd_q;

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) rdata_q <= mem_q[i_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) bd_q <= '0;
    else       bd_q <= mem_q[i_bd_addr];
  end

  assign o_rdata    = rdata_q;
  assign o_bd_rdata = bd_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave model of a 23K640-style serial SRAM.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_sck/i_cs/i_si : SPI from initiator (cs active low)
//   o_so, o_so_oe   : serial read/status data and its valid flag
//   i_bd_addr, o_bd_rdata : backdoor read of the array (1-cycle latency)
//   o_status        : status register {mode[1:0], 5'b0, hold}
// Commands: WRSR, RDSR, READ, WRITE. status[7:6] selects byte / page /
// sequential address advance.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int PAGE_W = 5,
  parameter int SYNC   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs,
  input  logic              i_si,
  output logic              o_so,
  output logic              o_so_oe,
  input  logic [ADDR_W-1:0] i_bd_addr,
  output logic [7:0]        o_bd_rdata,
  output logic [7:0]        o_status
);

  // Shift register holds just enough bits for a command byte or the
  // implemented address; upper address bits fall off the top.
  localparam int SR_W = (ADDR_W > 8) ? ADDR_W : 8;

  logic sck_s, cs_s, si_s;

  if (SYNC != 0) begin : g_sync
    logic [1:0] sck_ff_q, cs_ff_q, si_ff_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sck_ff_q <= '0;
        cs_ff_q  <= '1;
        si_ff_q  <= '0;
      end else begin
        sck_ff_q <= {sck_ff_q[0], i_sck};
        cs_ff_q  <= {cs_ff_q[0], i_cs};
        si_ff_q  <= {si_ff_q[0], i_si};
      end
    end
    assign sck_s = sck_ff_q[1];
    assign cs_s  = cs_ff_q[1];
    assign si_s  = si_ff_q[1];
  end else begin : g_nosync
    assign sck_s = i_sck;
    assign cs_s  = i_cs;
    assign si_s  = i_si;
  end

  state_e             state_q, state_d;
  logic               sck_prev_q, cs_prev_q;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [SR_W-2:0]    sr_q, sr_d;
  logic [SR_W-1:0]    sr_next;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, addr_next;
  logic [PAGE_W-1:0]  page_inc;
  logic [7:0]         tx_q, tx_d;
  logic               tx_load_q, tx_load_d;
  logic [2:0]         rd_cnt_q, rd_cnt_d;
  logic               rd_done_q, rd_done_d;
  logic [7:0]         status_q, status_d;
  logic               so_q, so_d, oe_q, oe_d;

  logic               mem_we, mem_re;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_wdata, mem_rdata;

  logic sck_rise, sck_fall, cs_fall, byte_mode;

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign sr_next   = {sr_q, si_s};
  assign byte_mode = (status_q[7:6] == MODE_BYTE) || (status_q[7:6] == 2'b11);
  assign page_inc  = addr_q[PAGE_W-1:0] + PAGE_W'(1);

  always_comb begin
    addr_next = addr_q + ADDR_W'(1);
    if (status_q[7:6] == MODE_PAGE) addr_next = {addr_q[ADDR_W-1:PAGE_W], page_inc};
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    tx_load_d = tx_load_q;
    rd_cnt_d  = rd_cnt_q;
    rd_done_d = rd_done_q;
    status_d  = status_q;
    so_d      = so_q;
    oe_d      = oe_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = sr_next[7:0];

    // CS high overrides everything, including a coincident SCK edge, so a
    // partial byte never reaches the array or the status register.
    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      so_d      = 1'b0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            sr_d      = sr_next[SR_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              case (sr_next[7:0])
                CMD_WRSR:  state_d = ST_WRSR;
                CMD_RDSR: begin
                  state_d  = ST_RDSR;
                  tx_d     = status_q;
                  rd_cnt_d = '0;
                end
                CMD_READ: begin
                  state_d = ST_ADDR;
                  rd_d    = 1'b1;
                end
                CMD_WRITE: begin
                  state_d = ST_ADDR;
                  rd_d    = 1'b0;
                end
                default:   state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            sr_d      = sr_next[SR_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = '0;
              addr_d    = sr_next[ADDR_W-1:0];
              if (rd_q) begin
                // Prefetch now; the registered array data is ready before
                // the first falling SCK and is consumed via tx_load.
                mem_re    = 1'b1;
                mem_addr  = sr_next[ADDR_W-1:0];
                tx_load_d = 1'b1;
                rd_cnt_d  = '0;
                rd_done_d = 1'b0;
                state_d   = ST_RD_DATA;
              end else begin
                state_d   = ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (sck_fall) begin
            if (rd_done_q) begin
              // Byte mode: bit 0 was held through its sampling edge; stop now.
              state_d = ST_IGNORE;
              so_d    = 1'b0;
              oe_d    = 1'b0;
            end else begin
              oe_d      = 1'b1;
              tx_load_d = 1'b0;
              if (tx_load_q) begin
                so_d = mem_rdata[7];
                tx_d = {mem_rdata[6:0], 1'b0};
              end else begin
                so_d = tx_q[7];
                tx_d = {tx_q[6:0], 1'b0};
              end
              rd_cnt_d = rd_cnt_q + 3'd1;
              if (rd_cnt_q == 3'd7) begin
                if (byte_mode) begin
                  rd_done_d = 1'b1;
                end else begin
                  addr_d    = addr_next;
                  mem_re    = 1'b1;
                  mem_addr  = addr_next;
                  tx_load_d = 1'b1;
                end
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (sck_rise) begin
            sr_d      = sr_next[SR_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              mem_we    = 1'b1;
              mem_addr  = addr_q;
              mem_wdata = sr_next[7:0];
              if (byte_mode) state_d = ST_IGNORE;
              else           addr_d  = addr_next;
            end
          end
        end
        ST_WRSR: begin
          if (sck_rise) begin
            sr_d      = sr_next[SR_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              status_d  = {sr_next[7:6], 5'b0, sr_next[0]};
              state_d   = ST_IGNORE;
            end
          end
        end
        ST_RDSR: begin
          if (sck_fall) begin
            oe_d = 1'b1;
            so_d = tx_q[7];
            if (rd_cnt_q == 3'd7) begin
              tx_d     = status_q;
              rd_cnt_d = '0;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              rd_cnt_d = rd_cnt_q + 3'd1;
            end
          end
        end
        ST_IGNORE: begin
          so_d = 1'b0;
          oe_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      tx_load_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_done_q  <= 1'b0;
      status_q   <= 8'h00;
      so_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      tx_load_q  <= tx_load_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_done_q  <= rd_done_d;
      status_q   <= status_d;
      so_q       <= so_d;
      oe_q       <= oe_d;
    end
  end

  spi_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (mem_we),
    .i_re       (mem_re),
    .i_addr     (mem_addr),
    .i_wdata    (mem_wdata),
    .o_rdata    (mem_rdata),
    .i_bd_addr  (i_bd_addr),
    .o_bd_rdata (o_bd_rdata)
  );

  assign o_so     = so_q;
  assign o_so_oe  = oe_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed + randomized bench for spi_sram_responder. Two instances
// (SYNC=0 and SYNC=1) are driven by the same SPI master and compared
// against a byte-array reference model.
module tb_spi_sram_responder;
  import spi_sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sck, cs, si;
  logic [12:0] bd_addr;
  logic [7:0]  bd_a, bd_b, st_a, st_b;

  spi_sram_responder_if ifa (.clk(clk));
  spi_sram_responder_if ifb (.clk(clk));

  assign ifa.sck = sck;
  assign ifa.cs  = cs;
  assign ifa.si  = si;
  assign ifb.sck = sck;
  assign ifb.cs  = cs;
  assign ifb.si  = si;

  spi_sram_responder #(.ADDR_W(13), .PAGE_W(5), .SYNC(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_sck(ifa.sck), .i_cs(ifa.cs), .i_si(ifa.si),
    .o_so(ifa.so), .o_so_oe(ifa.so_oe), .i_bd_addr(bd_addr),
    .o_bd_rdata(bd_a), .o_status(st_a)
  );

  spi_sram_responder #(.ADDR_W(13), .PAGE_W(5), .SYNC(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_sck(ifb.sck), .i_cs(ifb.cs), .i_si(ifb.si),
    .o_so(ifb.so), .o_so_oe(ifb.so_oe), .i_bd_addr(bd_addr),
    .o_bd_rdata(bd_b), .o_status(st_b)
  );

  // Reference model
  logic [7:0] mem_m [0:8191];
  logic [7:0] status_m;

  logic [7:0] txb [0:127];
  logic [7:0] dat [0:127];
  logic [7:0] rxa [0:127];
  logic [7:0] rxb [0:127];
  logic       oea [0:127];
  logic       oeb [0:127];
  logic       any_a, any_b;

  int checks   = 0;
  int failures = 0;

  function automatic bit is_byte_mode();
    return (status_m[7:6] == 2'b00) || (status_m[7:6] == 2'b11);
  endfunction

  function automatic int adv(input int x);
    if (status_m[7:6] == 2'b10) return (x & 'h1FE0) | ((x + 1) & 'h1F);
    return (x + 1) & 'h1FFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hp();
    repeat (4) @(negedge clk);
  endtask

  // One CS-low transaction: n whole bytes from txb, then extra_bits bits of
  // txb[n]. so/so_oe are sampled just before each rising SCK.
  task automatic xfer(input int n, input int extra_bits);
    any_a = 1'b0;
    any_b = 1'b0;
    cs = 1'b0; sck = 1'b0;
    hp();
    for (int k = 0; k < n; k++) begin
      oea[k] = 1'b1;
      oeb[k] = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        si = txb[k][i];
        hp();
        rxa[k][i] = ifa.so;
        rxb[k][i] = ifb.so;
        oea[k] = oea[k] & ifa.so_oe;
        oeb[k] = oeb[k] & ifb.so_oe;
        any_a = any_a | ifa.so | ifa.so_oe;
        any_b = any_b | ifb.so | ifb.so_oe;
        sck = 1'b1;
        hp();
        sck = 1'b0;
      end
    end
    for (int i = 0; i < extra_bits; i++) begin
      si = txb[n][7-i];
      hp();
      sck = 1'b1;
      hp();
      sck = 1'b0;
    end
    hp();
    cs = 1'b1;
    hp();
    hp();
  endtask

  task automatic wrsr(input logic [7:0] v);
    txb[0] = CMD_WRSR;
    txb[1] = v;
    xfer(2, 0);
    status_m = {v[7:6], 5'b0, v[0]};
    chk("status_a", st_a, status_m);
    chk("status_b", st_b, status_m);
  endtask

  task automatic spi_write(input int a, input int n);
    int x;
    txb[0] = CMD_WRITE;
    txb[1] = 8'(a >> 8);
    txb[2] = 8'(a);
    for (int k = 0; k < n; k++) txb[k+3] = dat[k];
    xfer(n + 3, 0);
    x = a & 'h1FFF;
    for (int k = 0; k < n; k++) begin
      mem_m[x] = dat[k];
      if (is_byte_mode()) break;
      x = adv(x);
    end
  endtask

  task automatic spi_read(input int a, input int n);
    int x;
    txb[0] = CMD_READ;
    txb[1] = 8'(a >> 8);
    txb[2] = 8'(a);
    for (int k = 0; k < n; k++) txb[k+3] = 8'($urandom);
    xfer(n + 3, 0);
    x = a & 'h1FFF;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("rd_a@%0h", x), rxa[k+3], mem_m[x]);
      chk($sformatf("rd_b@%0h", x), rxb[k+3], mem_m[x]);
      chk($sformatf("rdoe_a@%0h", x), oea[k+3], 1'b1);
      chk($sformatf("rdoe_b@%0h", x), oeb[k+3], 1'b1);
      x = adv(x);
    end
  endtask

  task automatic bd_chk(input int a);
    bd_addr = 13'(a);
    repeat (2) @(negedge clk);
    chk($sformatf("bd_a@%0h", a), bd_a, mem_m[a]);
    chk($sformatf("bd_b@%0h", a), bd_b, mem_m[a]);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_so_a", ifa.so, 1'b0);
    chk("rst_so_b", ifb.so, 1'b0);
    chk("rst_oe_a", ifa.so_oe, 1'b0);
    chk("rst_oe_b", ifb.so_oe, 1'b0);
    chk("rst_bd_a", bd_a, 8'h00);
    chk("rst_bd_b", bd_b, 8'h00);
    chk("rst_st_a", st_a, 8'h00);
    chk("rst_st_b", st_b, 8'h00);
    rst = 1'b0;
    status_m = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a, n, x;
    logic [7:0] v;
    rst = 1'b1; sck = 1'b0; cs = 1'b1; si = 1'b0; bd_addr = '0;
    status_m = 8'h00;
    reset_dut();

    // WRSR 0x41 then RDSR, two status bytes
    wrsr(8'h41);
    txb[0] = CMD_RDSR; txb[1] = 8'h00; txb[2] = 8'h00;
    xfer(3, 0);
    chk("rdsr0_a", rxa[1], 8'h41);
    chk("rdsr0_b", rxb[1], 8'h41);
    chk("rdsr1_a", rxa[2], 8'h41);
    chk("rdsr1_b", rxb[2], 8'h41);
    chk("rdsr_oe_a", oea[1] & oea[2], 1'b1);
    chk("rdsr_oe_b", oeb[1] & oeb[2], 1'b1);

    // Prefill regions used later so every checked address has a known value
    for (int k = 0; k < 80; k++) dat[k] = 8'($urandom);
    spi_write('h0000, 80);
    for (int k = 0; k < 16; k++) dat[k] = 8'($urandom);
    spi_write('h0120, 16);
    for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
    spi_write('h1FF8, 8);
    bd_chk('h0005);
    bd_chk('h1FFA);

    // Single write/read at 0x0123
    dat[0] = 8'hA5;
    spi_write('h0123, 1);
    spi_read('h0123, 1);
    bd_chk('h0123);

    // Sequential wrap at top of array
    dat[0] = 8'h11; dat[1] = 8'h22;
    spi_write('h1FFF, 2);
    bd_chk('h1FFF);
    bd_chk('h0000);
    spi_read('h1FFF, 2);

    // Page mode wrap within 0x0020..0x003F
    wrsr(8'h80);
    dat[0] = 8'hAA; dat[1] = 8'hBB;
    spi_write('h003F, 2);
    bd_chk('h003F);
    bd_chk('h0020);
    bd_chk('h0040);

    // Byte mode after reset: only the first data byte lands
    reset_dut();
    dat[0] = 8'h5A; dat[1] = 8'h6B;
    spi_write('h0010, 2);
    bd_chk('h0010);
    bd_chk('h0011);

    // CS raised 5 bits into a data byte: no write
    txb[0] = CMD_WRITE; txb[1] = 8'h00; txb[2] = 8'h20; txb[3] = 8'hC3;
    xfer(3, 5);
    bd_chk('h0020);

    // Unknown opcode: output stays quiet, next READ works
    txb[0] = 8'h9F; txb[1] = 8'hFF; txb[2] = 8'h55;
    xfer(3, 0);
    chk("ign_quiet_a", any_a, 1'b0);
    chk("ign_quiet_b", any_b, 1'b0);
    spi_read('h0010, 1);

    // Randomized mode / address / length
    for (int it = 0; it < 8; it++) begin
      v = {2'($urandom_range(0, 2)), 5'b0, 1'($urandom)};
      wrsr(v);
      a = $urandom_range(0, 'h47);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) dat[k] = 8'($urandom);
      spi_write(a, n);
      spi_read(a, is_byte_mode() ? 1 : n);
      x = a;
      for (int k = 0; k < n; k++) begin
        bd_chk(x);
        x = adv(x);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #3000000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
